// File: rtl/hub75_bcm_pkg.sv
// Shared HUB75 definitions: BCM sequencer state encoding and the default panel
// geometry also used by the column shifter and blanking stages.
package hub75_bcm_pkg;

  localparam int unsigned N_ROWS_DEF   = 32;
  localparam int unsigned N_PLANES_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_SHOW  = 3'd4
  } bcm_state_e;

endpackage

// File: rtl/hub75_bcm_plane_sel.sv
// Priority selector over a bit-plane enable mask: lowest enabled plane, next
// enabled plane above the current one, and whether the current one is the last.
module hub75_bcm_plane_sel #(
  parameter int unsigned N_PLANES     = 8,
  parameter int unsigned LOG_N_PLANES = $clog2(N_PLANES)
) (
  input  logic [N_PLANES-1:0]     mask,
  input  logic [LOG_N_PLANES-1:0] plane,
  output logic [LOG_N_PLANES-1:0] first_c,
  output logic [LOG_N_PLANES-1:0] next_c,
  output logic                    is_last_c
);

  // Descending scan: the last hit written is the lowest matching index.
  always_comb begin
    first_c   = '0;
    next_c    = '0;
    is_last_c = 1'b1;
    for (int i = int'(N_PLANES) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        first_c = LOG_N_PLANES'(i);
        if (i > int'(plane)) begin
          next_c    = LOG_N_PLANES'(i);
          is_last_c = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hub75_bcm.sv
// HUB75 binary-coded-modulation sequencer: per row, shift/latch/show each bit-plane.
// Optional plane skipping is enabled by defining HUB75_BCM_PLANE_MASK_EN.
module hub75_bcm
  import hub75_bcm_pkg::*;
#(
  parameter int unsigned N_ROWS       = N_ROWS_DEF,
  parameter int unsigned N_PLANES     = N_PLANES_DEF,
  parameter int unsigned LOG_N_ROWS   = $clog2(N_ROWS),
  parameter int unsigned LOG_N_PLANES = $clog2(N_PLANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LOG_N_ROWS-1:0]   bcm_row,
  input  logic                    bcm_row_first,
  input  logic                    bcm_go,
  output logic                    bcm_rdy,
  output logic [LOG_N_PLANES-1:0] shift_plane,
  output logic                    shift_go,
  input  logic                    shift_rdy,
  output logic [LOG_N_PLANES-1:0] blank_plane,
  output logic                    blank_go,
  input  logic                    blank_rdy,
  output logic [LOG_N_ROWS-1:0]   phy_addr,
  output logic                    phy_le,
  output logic                    frame_sync
`ifdef HUB75_BCM_PLANE_MASK_EN
  ,
  input  logic [N_PLANES-1:0]     ctrl_plane_ena
`endif
);

  bcm_state_e              state_q, state_d;
  logic [LOG_N_PLANES-1:0] plane_q, plane_d;
  logic [LOG_N_ROWS-1:0]   row_l_q, row_l_d;
  logic                    first_l_q, first_l_d;
  logic [LOG_N_ROWS-1:0]   addr_q, addr_d;
  logic                    shift_go_q, shift_go_d;
  logic                    blank_go_q, blank_go_d;
  logic                    phy_le_q, phy_le_d;
  logic                    frame_sync_q, frame_sync_d;
  logic                    rdy_q, rdy_d;

  logic                    go_acc_c;
  logic [LOG_N_PLANES-1:0] go_first_c;
  logic                    go_any_c;
  logic [LOG_N_PLANES-1:0] sel_first_c;
  logic [LOG_N_PLANES-1:0] sel_next_c;
  logic                    sel_last_c;

  assign go_acc_c = bcm_go & rdy_q;

`ifdef HUB75_BCM_PLANE_MASK_EN
  logic [N_PLANES-1:0] mask_q, mask_d;

  // Lowest enabled plane of the live mask, used to load the plane counter on go.
  always_comb begin
    go_first_c = '0;
    go_any_c   = 1'b0;
    for (int i = int'(N_PLANES) - 1; i >= 0; i--) begin
      if (ctrl_plane_ena[i]) begin
        go_first_c = LOG_N_PLANES'(i);
        go_any_c   = 1'b1;
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (state_q == ST_IDLE && go_acc_c) mask_d = ctrl_plane_ena;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  hub75_bcm_plane_sel #(
    .N_PLANES     (N_PLANES),
    .LOG_N_PLANES (LOG_N_PLANES)
  ) u_plane_sel (
    .mask      (mask_q),
    .plane     (plane_q),
    .first_c   (sel_first_c),
    .next_c    (sel_next_c),
    .is_last_c (sel_last_c)
  );
`else
  assign go_first_c  = '0;
  assign go_any_c    = 1'b1;
  assign sel_first_c = '0;
  assign sel_next_c  = plane_q + 1'b1;
  assign sel_last_c  = (plane_q == LOG_N_PLANES'(N_PLANES - 1));
`endif

  always_comb begin
    state_d   = state_q;
    plane_d   = plane_q;
    row_l_d   = row_l_q;
    first_l_d = first_l_q;
    addr_d    = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (go_acc_c) begin
          row_l_d   = bcm_row;
          first_l_d = bcm_row_first;
          if (go_any_c) begin
            plane_d = go_first_c;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: state_d = ST_WAIT;
      ST_WAIT: begin
        if (shift_rdy && blank_rdy) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        // Row address moves only together with the first plane of the new row.
        if (plane_q == sel_first_c) addr_d = row_l_q;
        state_d = ST_SHOW;
      end
      ST_SHOW: begin
        if (sel_last_c) begin
          state_d = ST_IDLE;
        end else begin
          plane_d = sel_next_c;
          state_d = ST_SHIFT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pulses are registered so they coincide with the state they belong to.
    shift_go_d   = (state_d == ST_SHIFT);
    blank_go_d   = (state_d == ST_SHOW);
    phy_le_d     = (state_d == ST_LATCH);
    frame_sync_d = (state_d == ST_LATCH) && first_l_q && (plane_q == sel_first_c);
    rdy_d        = (state_d == ST_IDLE) && !(state_q == ST_IDLE && go_acc_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      plane_q      <= '0;
      row_l_q      <= '0;
      first_l_q    <= 1'b0;
      addr_q       <= '0;
      shift_go_q   <= 1'b0;
      blank_go_q   <= 1'b0;
      phy_le_q     <= 1'b0;
      frame_sync_q <= 1'b0;
      rdy_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      plane_q      <= plane_d;
      row_l_q      <= row_l_d;
      first_l_q    <= first_l_d;
      addr_q       <= addr_d;
      shift_go_q   <= shift_go_d;
      blank_go_q   <= blank_go_d;
      phy_le_q     <= phy_le_d;
      frame_sync_q <= frame_sync_d;
      rdy_q        <= rdy_d;
    end
  end

  assign bcm_rdy     = rdy_q;
  assign shift_plane = plane_q;
  assign shift_go    = shift_go_q;
  assign blank_plane = plane_q;
  assign blank_go    = blank_go_q;
  assign phy_addr    = addr_q;
  assign phy_le      = phy_le_q;
  assign frame_sync  = frame_sync_q;

endmodule

// File: tb/tb_hub75_bcm.sv
// Scoreboard bench for hub75_bcm: stimulus queues expected pulses, a monitor
// pops and compares them on every shift_go / phy_le / blank_go.
module tb_hub75_bcm;

  localparam int unsigned LR = 5;
  localparam int unsigned LP = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [LR-1:0] bcm_row;
  logic          bcm_row_first;
  logic          bcm_go;
  logic          bcm_rdy;
  logic [LP-1:0] shift_plane;
  logic          shift_go;
  logic          shift_rdy;
  logic [LP-1:0] blank_plane;
  logic          blank_go;
  logic          blank_rdy;
  logic [LR-1:0] phy_addr;
  logic          phy_le;
  logic          frame_sync;
`ifdef HUB75_BCM_PLANE_MASK_EN
  logic [7:0]    mask_in;
`endif

  hub75_bcm #(.N_ROWS(32), .N_PLANES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .bcm_row       (bcm_row),
    .bcm_row_first (bcm_row_first),
    .bcm_go        (bcm_go),
    .bcm_rdy       (bcm_rdy),
    .shift_plane   (shift_plane),
    .shift_go      (shift_go),
    .shift_rdy     (shift_rdy),
    .blank_plane   (blank_plane),
    .blank_go      (blank_go),
    .blank_rdy     (blank_rdy),
    .phy_addr      (phy_addr),
    .phy_le        (phy_le),
    .frame_sync    (frame_sync)
`ifdef HUB75_BCM_PLANE_MASK_EN
    ,
    .ctrl_plane_ena (mask_in)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int plane;
    int aux;
  } exp_t;

  exp_t sq[$];
  exp_t lq[$];
  exp_t bq[$];
  exp_t me;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the head of its expectation queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (shift_go === 1'b1) begin
        if (sq.size() == 0) chk("shift_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          me = sq.pop_front();
          chk("shift_cycle", 32'(cyc), 32'(me.cyc));
          chk("shift_plane", 32'(shift_plane), 32'(me.plane));
        end
      end
      if (phy_le === 1'b1) begin
        if (lq.size() == 0) chk("le_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          me = lq.pop_front();
          chk("le_cycle", 32'(cyc), 32'(me.cyc));
          chk("le_frame_sync", 32'(frame_sync), 32'(me.aux));
        end
      end else if (frame_sync !== 1'b0) begin
        chk("frame_sync_stray", 32'(frame_sync), 32'd0);
      end
      if (blank_go === 1'b1) begin
        if (bq.size() == 0) chk("blank_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          me = bq.pop_front();
          chk("blank_cycle", 32'(cyc), 32'(me.cyc));
          chk("blank_plane", 32'(blank_plane), 32'(me.plane));
          chk("blank_phy_addr", 32'(phy_addr), 32'(me.aux));
        end
      end
    end
  end

  // Plane k (k-th enabled) of a row started at t: shift t+1+4k, latch t+3+4k,
  // show t+4+4k; a stall of d extra WAIT cycles delays everything after plane 0's shift.
  task automatic push_plan(input int t, input int row, input bit first, input int d,
                           input logic [7:0] mask);
    int k;
    exp_t e;
    k = 0;
    for (int p = 0; p < 8; p++) begin
      if (mask[p]) begin
        e.plane = p;
        e.cyc = t + 1 + 4 * k + ((k > 0) ? d : 0); e.aux = 0;
        sq.push_back(e);
        e.cyc = t + 3 + 4 * k + d; e.aux = (first && k == 0) ? 1 : 0;
        lq.push_back(e);
        e.cyc = t + 4 + 4 * k + d; e.aux = row;
        bq.push_back(e);
        k++;
      end
    end
  endtask

  task automatic run_row(input int row, input bit first, input int stall,
                         input logic [7:0] mask, input int prev_addr);
    int t, d, nk, exp_rdy;
    @(posedge clk); #1;
    t  = cyc;
    d  = (stall > 0) ? stall - 1 : 0;
    nk = $countones(mask);
    push_plan(t, row, first, d, mask);
    bcm_row       = LR'(row);
    bcm_row_first = first;
`ifdef HUB75_BCM_PLANE_MASK_EN
    mask_in = mask;
`endif
    if (stall > 0) blank_rdy = 1'b0;
    bcm_go = 1'b1;
    @(posedge clk); #1;
    bcm_go = 1'b0;
    if (nk >= 2) begin
      // A go while busy must be dropped.
      while (cyc < t + 6) begin @(posedge clk); #1; end
      bcm_row = LR'(17);
      bcm_go  = 1'b1;
      @(posedge clk); #1;
      bcm_go  = 1'b0;
      bcm_row = LR'(row);
    end
    if (stall > 0) begin
      while (cyc < t + 10) begin @(posedge clk); #1; end
      chk("stall_addr_held", 32'(phy_addr), 32'(prev_addr));
      while (cyc < t + stall + 1) begin @(posedge clk); #1; end
      blank_rdy = 1'b1;
    end
    exp_rdy = (nk == 0) ? t + 2 : t + 1 + 4 * nk + d;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bcm_rdy === 1'b1) break;
    end
    chk("rdy_return_cycle", 32'(cyc), 32'(exp_rdy));
    chk("row_end_addr", 32'(phy_addr), 32'((nk == 0) ? prev_addr : row));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    bcm_go = 1'b0;
    bcm_row = '0;
    bcm_row_first = 1'b0;
    shift_rdy = 1'b1;
    blank_rdy = 1'b1;
`ifdef HUB75_BCM_PLANE_MASK_EN
    mask_in = 8'hFF;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rdy", 32'(bcm_rdy), 32'd1);
    chk("reset_shift_go", 32'(shift_go), 32'd0);
    chk("reset_blank_go", 32'(blank_go), 32'd0);
    chk("reset_phy_le", 32'(phy_le), 32'd0);
    chk("reset_frame_sync", 32'(frame_sync), 32'd0);
    chk("reset_phy_addr", 32'(phy_addr), 32'd0);
    chk("reset_plane", 32'(shift_plane), 32'd0);

    run_row(5, 1'b0, 0, 8'hFF, 0);
    run_row(9, 1'b0, 20, 8'hFF, 5);
    run_row(0, 1'b1, 0, 8'hFF, 9);
    run_row(1, 1'b0, 0, 8'hFF, 0);
`ifdef HUB75_BCM_PLANE_MASK_EN
    run_row(12, 1'b0, 0, 8'b1010_0001, 1);
    run_row(13, 1'b0, 0, 8'h00, 12);
    mask_in = 8'hFF;
`endif

    // Reset during plane 3 display: planes 0..3 complete, nothing afterwards.
    @(posedge clk); #1;
    t = cyc;
    push_plan(t, 3, 1'b0, 0, 8'h0F);
    bcm_row = LR'(3);
    bcm_row_first = 1'b0;
    bcm_go = 1'b1;
    @(posedge clk); #1;
    bcm_go = 1'b0;
    while (cyc < t + 16) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_reset_addr", 32'(phy_addr), 32'd3);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rdy", 32'(bcm_rdy), 32'd1);
    chk("midrst_addr", 32'(phy_addr), 32'd0);
    chk("midrst_blank_go", 32'(blank_go), 32'd0);
    chk("midrst_shift_go", 32'(shift_go), 32'd0);
    repeat (12) @(negedge clk);
    chk("midrst_rdy_hold", 32'(bcm_rdy), 32'd1);

    chk("shift_queue_drained", 32'(sq.size()), 32'd0);
    chk("le_queue_drained", 32'(lq.size()), 32'd0);
    chk("blank_queue_drained", 32'(bq.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
